// File: rtl/nlc_sample_feeder_if.sv
// Sample-stream bundle between the ADC front end, the feeder and the
// non-linearity correction engine. The feeder is the slave side: it takes
// samples and the engine's done strobe, and it drives the engine's sample
// and start pulse.
interface nlc_sample_feeder_if;
  logic [20:0] i_x;
  logic        i_srdyi;
  logic [20:0] o_x;
  logic        o_srdyo;
  logic        i_nlc_done;

  modport master (
    output i_x,
    output i_srdyi,
    output i_nlc_done,
    input  o_x,
    input  o_srdyo
  );

  modport slave (
    input  i_x,
    input  i_srdyi,
    input  i_nlc_done,
    output o_x,
    output o_srdyo
  );
endinterface

// File: rtl/nlc_sample_feeder.sv
// Buffers ADC samples in a small FIFO and hands them one at a time to the
// correction engine. Each sample gets a one-cycle start pulse; the feeder
// then waits for the engine's done strobe (or a watchdog expiry) and
// inserts a gap cycle before the next sample. DEPTH must be a power of
// two, at least 2.
module nlc_sample_feeder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  nlc_sample_feeder_if.slave       bus,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_busy,
  output logic                     o_overflow,
  output logic                     o_timeout
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW:0]    CNT_ZERO = '0;
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1'b1);
  localparam logic [WDW-1:0] WD_ZERO  = '0;
  localparam logic [WDW-1:0] WD_ONE   = WDW'(1'b1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_GAP   = 2'b11
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;

  logic [20:0]     mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic [AW:0]     count_nxt_s;
  logic            full_r;
  logic            busy_r;
  logic [20:0]     x_r;
  logic            srdyo_r;
  logic            overflow_r;
  logic            timeout_r;
  logic [WDW-1:0]  wd_r;
  logic [WDW-1:0]  wd_nxt_s;

  logic            push_s;
  logic            drop_s;
  logic            pop_s;
  logic            expire_s;

  // State register; reset discards whatever sample is in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the engine's done strobe only matters while waiting.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_ZERO) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.i_nlc_done) begin
          state_nxt_s = ST_GAP;
        end else if (wd_r == WD_LAST) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_GAP:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath decode: FIFO push/pop/drop, watchdog and expiry.
  always_comb begin
    push_s   = bus.i_srdyi & ~full_r;
    drop_s   = bus.i_srdyi & full_r;
    pop_s    = 1'b0;
    expire_s = 1'b0;
    wd_nxt_s = WD_ZERO;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_ZERO) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_ISSUE: wd_nxt_s = WD_ZERO;
      ST_WAIT: begin
        wd_nxt_s = wd_r + WD_ONE;
        if (!bus.i_nlc_done && (wd_r == WD_LAST)) begin
          expire_s = 1'b1;
        end else begin
          expire_s = 1'b0;
        end
      end
      ST_GAP:  wd_nxt_s = WD_ZERO;
      default: wd_nxt_s = WD_ZERO;
    endcase
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Registered pointers, occupancy, engine outputs and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      busy_r     <= 1'b0;
      x_r        <= 21'd0;
      srdyo_r    <= 1'b0;
      overflow_r <= 1'b0;
      timeout_r  <= 1'b0;
      wd_r       <= WD_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      busy_r  <= (state_nxt_s != ST_IDLE);
      // o_x is loaded only when a sample is issued, so it stays put
      // through WAIT and GAP while the engine keeps re-sampling it.
      if (pop_s)    x_r        <= mem_r[rd_ptr_r];
      srdyo_r <= pop_s;
      if (drop_s)   overflow_r <= 1'b1;
      if (expire_s) timeout_r  <= 1'b1;
      wd_r <= wd_nxt_s;
    end
  end

  // Sample storage; not cleared by reset, and a sample offered during reset is not kept.
  always_ff @(posedge i_clk) begin
    if (!i_reset && push_s) begin
      mem_r[wr_ptr_r] <= bus.i_x;
    end
  end

  assign bus.o_x     = x_r;
  assign bus.o_srdyo = srdyo_r;
  assign o_count     = count_r;
  assign o_full      = full_r;
  assign o_busy      = busy_r;
  assign o_overflow  = overflow_r;
  assign o_timeout   = timeout_r;

endmodule

// File: tb/tb_nlc_sample_feeder.sv
// Directed bench for nlc_sample_feeder. Accepted samples are queued as
// expected issues; a monitor pops and compares on every start pulse, and
// a small engine model answers each pulse with a done strobe.
module tb_nlc_sample_feeder;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic       full, busy, ovf, tmo;

  nlc_sample_feeder_if bus();

  nlc_sample_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .bus        (bus),
    .o_count    (count),
    .o_full     (full),
    .o_busy     (busy),
    .o_overflow (ovf),
    .o_timeout  (tmo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic signed [20:0] sb_q[$];

  bit eng_stall;
  int eng_lat;
  int eng_cnt;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Engine model: answers a start pulse eng_lat cycles later (0 = never).
  initial begin
    forever begin
      @(negedge clk);
      bus.i_nlc_done = 1'b0;
      if (eng_cnt > 0 && !eng_stall) begin
        eng_cnt--;
        if (eng_cnt == 0) bus.i_nlc_done = 1'b1;
      end
      if (bus.o_srdyo === 1'b1) eng_cnt = eng_lat;
    end
  end

  // Monitor: order of issued samples, spacing between pulses, o_x hold.
  initial begin : monitor
    int c;
    int last_issue;
    logic [20:0] last_x;
    logic signed [20:0] exp_x;
    c = 0;
    last_issue = -100;
    last_x = 21'd0;
    forever begin
      @(negedge clk);
      c++;
      if (bus.o_srdyo === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_issue: got x=%0d, expected no issue", $signed(bus.o_x));
        end else begin
          exp_x = sb_q.pop_front();
          check("issue_x", $signed(bus.o_x), exp_x);
        end
        check("issue_spacing_ge4", ((c - last_issue) >= 4) ? 1 : 0, 1);
        last_issue = c;
        last_x = bus.o_x;
      end else if (busy === 1'b1) begin
        check("o_x_hold", bus.o_x, last_x);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_srdyi = 1'b0;
    sb_q.delete();
    eng_cnt = 0;
    eng_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one sample at the next edge; returns at the following negedge.
  task automatic push(input logic signed [20:0] x, input bit stored);
    bus.i_x = x;
    bus.i_srdyi = 1'b1;
    if (stored) sb_q.push_back(x);
    @(negedge clk);
    bus.i_srdyi = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int k = 0;
    while (!(count == 4'd0 && busy === 1'b0) && k < max) begin
      @(negedge clk);
      k++;
    end
    check(name, (k < max) ? 1 : 0, 1);
    check({name, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500000");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    rst = 1'b1;
    bus.i_x = 21'd0;
    bus.i_srdyi = 1'b0;
    bus.i_nlc_done = 1'b0;
    eng_stall = 1'b0;
    eng_lat = 3;
    eng_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_srdyo", bus.o_srdyo, 0);
    check("rst_o_x", bus.o_x, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tmo", tmo, 0);
    check("rst_full", full, 0);

    // Single sample, engine answers 40 cycles after the pulse
    eng_lat = 40;
    push(-21'sd50000, 1'b1);
    check("single_e0_srdyo", bus.o_srdyo, 0);
    check("single_e0_count", count, 1);
    @(negedge clk);
    check("single_e1_srdyo", bus.o_srdyo, 1);
    check("single_e1_x", $signed(bus.o_x), -50000);
    check("single_e1_busy", busy, 1);
    check("single_e1_count", count, 0);
    @(negedge clk);
    check("single_e2_srdyo", bus.o_srdyo, 0);
    k = 1;
    while (busy === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("single_idle_cycle", k, 42);
    check("single_count", count, 0);

    // Burst of 8 with the engine stalled, then released
    do_reset();
    eng_lat = 3;
    eng_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(21'(i), 1'b1);
      check("burst_count", count, (i == 0) ? 1 : i);
      check("burst_full", full, 0);
    end
    eng_stall = 1'b0;
    wait_idle(500, "burst_drain");

    // Overflow: 10 back-to-back, the 10th is dropped
    do_reset();
    eng_lat = 2;
    eng_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(21'(100 + i), (i < 9));
      check("ovf_flag_step", ovf, (i == 9) ? 1 : 0);
    end
    check("ovf_full", full, 1);
    check("ovf_count", count, 8);
    eng_stall = 1'b0;
    wait_idle(500, "ovf_drain");
    check("ovf_sticky", ovf, 1);
    check("ovf_full_after", full, 0);

    // Timeout: no done for the first sample, second one follows
    do_reset();
    eng_lat = 0;
    push(21'sd7, 1'b1);
    push(21'sd8, 1'b1);
    check("tmo_issue_a", bus.o_srdyo, 1);
    @(negedge clk);
    eng_lat = 5;
    repeat (254) @(negedge clk);
    check("tmo_before_expiry", tmo, 0);
    check("tmo_wait_busy", busy, 1);
    @(negedge clk);
    check("tmo_set", tmo, 1);
    k = 0;
    while (bus.o_srdyo !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("tmo_next_issue_delay", k, 2);
    wait_idle(200, "tmo_drain");
    check("tmo_sticky", tmo, 1);

    // Push and pop on the same ISSUE edge with three samples queued
    do_reset();
    eng_lat = 2;
    eng_stall = 1'b1;
    push(21'sd10, 1'b1);
    push(21'sd11, 1'b1);
    push(21'sd12, 1'b1);
    push(21'sd13, 1'b1);
    check("pp_count_before", count, 3);
    eng_stall = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < 50);
    check("pp_reached_idle", (k < 50) ? 1 : 0, 1);
    check("pp_idle_count", count, 3);
    push(21'sd14, 1'b1);
    check("pp_issue_srdyo", bus.o_srdyo, 1);
    check("pp_count_after", count, 3);
    wait_idle(300, "pp_drain");

    // Reset while waiting, with a sample offered during reset
    do_reset();
    eng_lat = 2;
    eng_stall = 1'b1;
    for (int i = 0; i < 5; i++) push(21'(20 + i), 1'b1);
    repeat (3) @(negedge clk);
    check("rw_count_before", count, 4);
    check("rw_busy_before", busy, 1);
    rst = 1'b1;
    bus.i_x = 21'sd99;
    bus.i_srdyi = 1'b1;
    sb_q.delete();
    eng_cnt = 0;
    eng_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.i_srdyi = 1'b0;
    check("rw_count", count, 0);
    check("rw_busy", busy, 0);
    check("rw_o_x", bus.o_x, 0);
    check("rw_srdyo", bus.o_srdyo, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rw_quiet_srdyo", bus.o_srdyo, 0);
      check("rw_quiet_count", count, 0);
    end
    push(21'sd30, 1'b1);
    @(negedge clk);
    check("rw_new_issue", bus.o_srdyo, 1);
    wait_idle(100, "rw_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
